// File: rtl/bank_array_pkg.sv
// Shared types and geometry helpers for the interleaved bank array.
package bank_array_pkg;

    // Clear engine states: sweeping zeros through every row, or serving traffic.
    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } state_t;

    // Bank index width: low address bits select the bank.
    function automatic int bank_w(input int num_banks);
        return $clog2(num_banks);
    endfunction

    // Rows per bank: total words spread evenly across the banks.
    function automatic int rows(input int addr_w, input int num_banks);
        return (1 << addr_w) / num_banks;
    endfunction

    // One byte-enable bit per byte of the data word.
    function automatic int be_w(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/bank_ram.sv
// One physical bank: ROWS x DATA_W, one byte-enabled write port and one
// synchronous read port. The read register updates only on a read enable,
// so it keeps its value between reads. Same-row read/write returns old data.
module bank_ram #(
    parameter int DATA_W = 128,
    parameter int ROWS   = 32,
    parameter int ROW_W  = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we,
    input  logic [ROW_W-1:0]      waddr,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [DATA_W/8-1:0]   wbe,
    input  logic                  re,
    input  logic [ROW_W-1:0]      raddr,
    output logic [DATA_W-1:0]     rdata
);

    logic [DATA_W-1:0] mem [ROWS];

    // Byte-granular write into the storage array.
    // NOTE: storage has no reset so it maps onto RAM macros; the clear engine zeroes it instead.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < DATA_W/8; i++) begin
                if (wbe[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    // Registered read; sees pre-write contents on a same-row collision.
    // NOTE: non-blocking assignments on all sequential state keep read-first ordering race-free.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/bank_array.sv
// Word-interleaved storage array: 2^ADDR_W words of DATA_W bits spread over
// NUM_BANKS banks (bank = low address bits, row = high bits), with a clear
// engine that zeroes every row after reset or on vsi_clear.
// Optional macro BANK_ARRAY_BYPASS_EN: same-address read/write returns the
// merged (write-first) word instead of the old contents.
module bank_array
    import bank_array_pkg::*;
#(
    parameter int DATA_W    = 128,
    parameter int ADDR_W    = 7,
    parameter int NUM_BANKS = 4
) (
    input  logic                  vsi_clk,
    input  logic                  vsi_reset_n,
    input  logic                  vsi_clear,
    output logic                  vsi_ready,
    input  logic                  vsi_inputChipSelect,
    input  logic [ADDR_W-1:0]     vsi_inputAddr,
    input  logic [DATA_W-1:0]     vsi_inputData,
    input  logic [DATA_W/8-1:0]   vsi_inputByteEn,
    input  logic                  vsi_outputChipSelect,
    input  logic [ADDR_W-1:0]     vsi_outputAddr,
    output logic [DATA_W-1:0]     vsi_outputData,
    output logic                  vsi_outputValid
);

    localparam int BANK_W = bank_w(NUM_BANKS);
    localparam int ROWS   = rows(ADDR_W, NUM_BANKS);
    localparam int BE_W   = be_w(DATA_W);
    localparam int ROW_W  = ADDR_W - BANK_W;

    state_t             state;
    logic [ROW_W-1:0]   row_cnt;
    logic               clearing;
    logic               wr_acc;
    logic               rd_acc;
    logic [BANK_W-1:0]  wr_bank;
    logic [BANK_W-1:0]  rd_bank;
    logic [ROW_W-1:0]   wr_row;
    logic [ROW_W-1:0]   rd_row;
    logic [BANK_W-1:0]  rd_sel;
    logic [ROW_W-1:0]   bank_waddr;
    logic [DATA_W-1:0]  bank_wdata;
    logic [BE_W-1:0]    bank_wbe;
    logic [DATA_W-1:0]  bank_rdata [NUM_BANKS];

    assign clearing  = (state == CLEAR);
    assign vsi_ready = (state == IDLE);

    // Traffic is accepted only when ready and not in the same cycle as a clear request.
    assign wr_acc = vsi_ready && !vsi_clear && vsi_inputChipSelect;
    assign rd_acc = vsi_ready && !vsi_clear && vsi_outputChipSelect;

    assign wr_bank = vsi_inputAddr[BANK_W-1:0];
    assign wr_row  = vsi_inputAddr[ADDR_W-1:BANK_W];
    assign rd_bank = vsi_outputAddr[BANK_W-1:0];
    assign rd_row  = vsi_outputAddr[ADDR_W-1:BANK_W];

    // During the sweep every bank writes zeros to the same row at once.
    assign bank_waddr = clearing ? row_cnt : wr_row;
    assign bank_wdata = clearing ? '0 : vsi_inputData;
    assign bank_wbe   = clearing ? '1 : vsi_inputByteEn;

    // Clear engine: sweep rows 0..ROWS-1, then serve traffic until the next clear request.
    always_ff @(posedge vsi_clk or negedge vsi_reset_n) begin
        if (!vsi_reset_n) begin
            state   <= CLEAR;
            row_cnt <= '0;
        end else begin
            case (state)
                CLEAR: begin
                    row_cnt <= row_cnt + 1'b1;
                    if (row_cnt == ROW_W'(ROWS - 1)) state <= IDLE;
                end
                IDLE: begin
                    if (vsi_clear) begin
                        state   <= CLEAR;
                        row_cnt <= '0;
                    end
                end
                default: state <= CLEAR;
            endcase
        end
    end

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        logic we;
        logic re;

        assign we = clearing || (wr_acc && (wr_bank == BANK_W'(b)));
        assign re = rd_acc && (rd_bank == BANK_W'(b));

        bank_ram #(
            .DATA_W (DATA_W),
            .ROWS   (ROWS),
            .ROW_W  (ROW_W)
        ) u_ram (
            .clk   (vsi_clk),
            .rst_n (vsi_reset_n),
            .we    (we),
            .waddr (bank_waddr),
            .wdata (bank_wdata),
            .wbe   (bank_wbe),
            .re    (re),
            .raddr (rd_row),
            .rdata (bank_rdata[b])
        );
    end

    // Track which bank answers the last accepted read and flag fresh results.
    always_ff @(posedge vsi_clk or negedge vsi_reset_n) begin
        if (!vsi_reset_n) begin
            rd_sel          <= '0;
            vsi_outputValid <= 1'b0;
        end else begin
            vsi_outputValid <= rd_acc;
            if (rd_acc) rd_sel <= rd_bank;
        end
    end

`ifdef BANK_ARRAY_BYPASS_EN
    logic               byp_hit;
    logic [DATA_W-1:0]  byp_data;
    logic [BE_W-1:0]    byp_be;

    // Capture a same-address write alongside the read so its bytes can override old data.
    always_ff @(posedge vsi_clk or negedge vsi_reset_n) begin
        if (!vsi_reset_n) begin
            byp_hit  <= 1'b0;
            byp_data <= '0;
            byp_be   <= '0;
        end else if (rd_acc) begin
            byp_hit  <= wr_acc && (vsi_inputAddr == vsi_outputAddr);
            byp_data <= vsi_inputData;
            byp_be   <= vsi_inputByteEn;
        end
    end

    // Merge written bytes over the bank's pre-write word.
    // NOTE: output gets its full default first so no path leaves it unassigned (no latch).
    always_comb begin
        vsi_outputData = bank_rdata[rd_sel];
        if (byp_hit) begin
            for (int i = 0; i < BE_W; i++) begin
                if (byp_be[i]) vsi_outputData[8*i +: 8] = byp_data[8*i +: 8];
            end
        end
    end
`else
    assign vsi_outputData = bank_rdata[rd_sel];
`endif

endmodule

// File: tb/tb_bank_array.sv
// Directed, table-driven bench for bank_array at default parameters.
module tb_bank_array;

    localparam int DATA_W = 128;
    localparam int ADDR_W = 7;
    localparam int BE_W   = DATA_W / 8;
    localparam int CLEAR_CYCLES = 32;
    localparam int MAX_WAIT = 100;

    logic              clk;
    logic              rst_n;
    logic              clear;
    logic              ready;
    logic              wr_cs;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [BE_W-1:0]   wr_be;
    logic              rd_cs;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;

    int n_checks = 0;
    int n_fail   = 0;

    bank_array u_dut (
        .vsi_clk              (clk),
        .vsi_reset_n          (rst_n),
        .vsi_clear            (clear),
        .vsi_ready            (ready),
        .vsi_inputChipSelect  (wr_cs),
        .vsi_inputAddr        (wr_addr),
        .vsi_inputData        (wr_data),
        .vsi_inputByteEn      (wr_be),
        .vsi_outputChipSelect (rd_cs),
        .vsi_outputAddr       (rd_addr),
        .vsi_outputData       (rd_data),
        .vsi_outputValid      (rd_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic              wcs;
        logic [ADDR_W-1:0] waddr;
        logic [DATA_W-1:0] wdata;
        logic [BE_W-1:0]   wbe;
        logic              rcs;
        logic [ADDR_W-1:0] raddr;
        logic              exp_valid;
        logic [DATA_W-1:0] exp_data;
    } vec_t;

    localparam logic [DATA_W-1:0] D1   = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    localparam logic [DATA_W-1:0] D2   = 128'h00112233_44556677_8899AABB_FFFFFFFF;
    localparam logic [DATA_W-1:0] D3   = 128'h00000000_44556677_8899AABB_FFFFFFFF;
    localparam logic [DATA_W-1:0] A5   = {16{8'hA5}};
    localparam logic [DATA_W-1:0] XD   = 128'hDEADBEEF_0BADF00D_CAFEBABE_12345678;
    localparam logic [DATA_W-1:0] ONES = '1;
`ifdef BANK_ARRAY_BYPASS_EN
    localparam logic [DATA_W-1:0] COLL_2A = A5;
    localparam logic [DATA_W-1:0] COLL_05 = D3;
`else
    localparam logic [DATA_W-1:0] COLL_2A = '0;
    localparam logic [DATA_W-1:0] COLL_05 = D2;
`endif

    vec_t vecs[13];

    task automatic check(input string name, input logic [DATA_W-1:0] act,
                         input logic [DATA_W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        clear   = 1'b0;
        wr_cs   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        wr_be   = '0;
        rd_cs   = 1'b0;
        rd_addr = '0;
    endtask

    // Count cycles until ready rises, bounded so a stuck DUT still reaches the summary.
    task automatic wait_ready(input string name);
        int cnt = 0;
        while (!ready && cnt < MAX_WAIT) begin
            tick();
            cnt++;
        end
        check(name, DATA_W'(cnt), DATA_W'(CLEAR_CYCLES));
    endtask

    task automatic read_all_zero(input string name);
        for (int a = 0; a < (1 << ADDR_W); a++) begin
            rd_cs   = 1'b1;
            rd_addr = ADDR_W'(a);
            tick();
            check($sformatf("%s_valid_%0d", name, a), DATA_W'(rd_valid), DATA_W'(1));
            check($sformatf("%s_data_%0d", name, a), rd_data, '0);
        end
        rd_cs = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{1'b1, 7'h05, D1,   16'hFFFF, 1'b0, 7'h00, 1'b0, '0};
        vecs[1]  = '{1'b0, 7'h00, '0,   16'h0000, 1'b1, 7'h05, 1'b1, D1};
        vecs[2]  = '{1'b1, 7'h05, ONES, 16'h000F, 1'b1, 7'h03, 1'b1, '0};
        vecs[3]  = '{1'b0, 7'h00, '0,   16'h0000, 1'b1, 7'h05, 1'b1, D2};
        vecs[4]  = '{1'b1, 7'h2A, A5,   16'hFFFF, 1'b1, 7'h2A, 1'b1, COLL_2A};
        vecs[5]  = '{1'b0, 7'h00, '0,   16'h0000, 1'b1, 7'h2A, 1'b1, A5};
        vecs[6]  = '{1'b1, 7'h2E, XD,   16'hFFFF, 1'b1, 7'h2A, 1'b1, A5};
        vecs[7]  = '{1'b0, 7'h00, '0,   16'h0000, 1'b1, 7'h2E, 1'b1, XD};
        vecs[8]  = '{1'b1, 7'h2E, ONES, 16'h0000, 1'b1, 7'h2E, 1'b1, XD};
        vecs[9]  = '{1'b0, 7'h00, '0,   16'h0000, 1'b1, 7'h2E, 1'b1, XD};
        vecs[10] = '{1'b1, 7'h05, '0,   16'hF000, 1'b1, 7'h05, 1'b1, COLL_05};
        vecs[11] = '{1'b0, 7'h00, '0,   16'h0000, 1'b1, 7'h05, 1'b1, D3};
        vecs[12] = '{1'b0, 7'h00, '0,   16'h0000, 1'b0, 7'h00, 1'b0, D3};

        // Reset state.
        idle_inputs();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        check("reset_ready", DATA_W'(ready), '0);
        check("reset_valid", DATA_W'(rd_valid), '0);
        check("reset_data", rd_data, '0);
        #9 rst_n = 1'b1;

        // Initial sweep length and zeroed contents.
        wait_ready("init_clear_cycles");
        read_all_zero("init");
        tick();
        check("idle_valid_low", DATA_W'(rd_valid), '0);

        // Directed write/read vectors, including collisions and byte enables.
        for (int i = 0; i < 13; i++) begin
            wr_cs   = vecs[i].wcs;
            wr_addr = vecs[i].waddr;
            wr_data = vecs[i].wdata;
            wr_be   = vecs[i].wbe;
            rd_cs   = vecs[i].rcs;
            rd_addr = vecs[i].raddr;
            tick();
            check($sformatf("vec%0d_valid", i), DATA_W'(rd_valid), DATA_W'(vecs[i].exp_valid));
            check($sformatf("vec%0d_data", i), rd_data, vecs[i].exp_data);
        end
        idle_inputs();

        // Fill every word with its own address.
        for (int a = 0; a < (1 << ADDR_W); a++) begin
            wr_cs   = 1'b1;
            wr_addr = ADDR_W'(a);
            wr_data = DATA_W'(a);
            wr_be   = '1;
            tick();
        end
        idle_inputs();
        rd_cs = 1'b1; rd_addr = 7'h7F;
        tick();
        check("fill_read_7f", rd_data, DATA_W'(8'h7F));
        rd_addr = 7'h10;
        tick();
        check("fill_read_10", rd_data, DATA_W'(8'h10));
        rd_cs = 1'b0;

        // Clear pulse with a simultaneous write; a read and a second clear inside the sweep.
        clear = 1'b1; wr_cs = 1'b1; wr_addr = 7'h10; wr_data = ONES; wr_be = '1;
        tick();
        idle_inputs();
        check("clear_ready_low", DATA_W'(ready), '0);
        rd_cs = 1'b1; rd_addr = 7'h10;
        begin
            int cnt = 0;
            while (!ready && cnt < MAX_WAIT) begin
                tick();
                cnt++;
                if (cnt == 1) begin
                    check("clear_read_dropped", DATA_W'(rd_valid), '0);
                    rd_cs = 1'b0;
                end
                if (cnt == 5) clear = 1'b1;
                if (cnt == 6) clear = 1'b0;
            end
            check("clear_cycles", DATA_W'(cnt), DATA_W'(CLEAR_CYCLES));
        end
        idle_inputs();
        read_all_zero("after_clear");

        // Reset in the middle of a sweep, with non-zero data on the output.
        wr_cs = 1'b1; wr_addr = 7'h05; wr_data = D1; wr_be = '1;
        tick();
        idle_inputs();
        rd_cs = 1'b1; rd_addr = 7'h05;
        tick();
        check("pre_reset_data", rd_data, D1);
        rd_cs = 1'b0;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        repeat (10) tick();
        check("mid_clear_ready", DATA_W'(ready), '0);
        check("mid_clear_data_held", rd_data, D1);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_data", rd_data, '0);
        check("async_reset_valid", DATA_W'(rd_valid), '0);
        check("async_reset_ready", DATA_W'(ready), '0);
        #2 rst_n = 1'b1;
        wait_ready("reset_restart_cycles");
        rd_cs = 1'b1; rd_addr = 7'h05;
        tick();
        check("post_reset_read_valid", DATA_W'(rd_valid), DATA_W'(1));
        check("post_reset_read_data", rd_data, '0);
        idle_inputs();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
